// File: rtl/bus_err_axi_tap_pkg.sv
// bus_err_axi_tap_pkg: shared AXI response codes, channel indices and request entry type for the tap
package bus_err_axi_tap_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam int unsigned CH_RD = 0;
  localparam int unsigned CH_WR = 1;
  localparam int unsigned TAP_ADDR_W = 48;
  localparam int unsigned TAP_META_W = 1;
  typedef struct packed {
    logic [TAP_ADDR_W-1:0] addr;
    logic [TAP_META_W-1:0] meta;
  } req_entry_t;
  function automatic logic [1:0] rr_pick(input logic [1:0] elig, input logic ptr);
    return &elig ? (ptr ? 2'b10 : 2'b01) : elig;
  endfunction
endpackage

// File: rtl/bus_err_tap_fifo.sv
// bus_err_tap_fifo: fall-through queue; an empty queue forwards data_i combinationally
module bus_err_tap_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PtrW:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == FullCnt;
  assign data_o  = empty_o ? data_i : mem_q[rd_q];
  // a push popped in the same cycle while empty bypasses storage entirely
  always_comb begin
    wr_en = push_i && (!full_o || pop_i) && !(empty_o && pop_i);
    rd_en = pop_i && !empty_o;
    wr_d  = wr_en ? (wr_q == LastPtr ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = rd_en ? (rd_q == LastPtr ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = (wr_en && !rd_en) ? cnt_q + 1'b1 : (rd_en && !wr_en) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/bus_err_axi_tap.sv
// bus_err_axi_tap: passive AXI4 monitor turning AR/R and AW/B handshakes into one-hot error-unit events
module bus_err_axi_tap
  import bus_err_axi_tap_pkg::*;
#(
  parameter int unsigned AddrWidth      = TAP_ADDR_W,
  parameter int unsigned MetaDataWidth  = TAP_META_W,
  parameter int unsigned ErrBits        = 3,
  parameter int unsigned QueueDepth     = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ar_valid_i,
  input  logic                     ar_ready_i,
  input  logic [AddrWidth-1:0]     ar_addr_i,
  input  logic [MetaDataWidth-1:0] ar_meta_i,
  input  logic                     aw_valid_i,
  input  logic                     aw_ready_i,
  input  logic [AddrWidth-1:0]     aw_addr_i,
  input  logic [MetaDataWidth-1:0] aw_meta_i,
  input  logic                     r_valid_i,
  input  logic                     r_ready_i,
  input  logic                     r_last_i,
  input  logic [1:0]               r_resp_i,
  input  logic                     b_valid_i,
  input  logic                     b_ready_i,
  input  logic [1:0]               b_resp_i,
  input  logic                     clear_i,
  output logic [1:0]               req_hs_valid_o,
  output logic [AddrWidth-1:0]     req_addr_o,
  output logic [MetaDataWidth-1:0] req_meta_o,
  output logic [1:0]               rsp_hs_valid_o,
  output logic [1:0]               rsp_burst_last_o,
  output logic [ErrBits-1:0]       rsp_err_o,
  output logic                     overflow_o
);
  localparam int unsigned ReqW = AddrWidth + MetaDataWidth;
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);
  logic [1:0] req_push, req_pop, req_full, req_empty, req_elig;
  logic [1:0] rsp_push, rsp_pop, rsp_full, rsp_empty, rsp_elig;
  logic [1:0][ReqW-1:0] req_din, req_dout;
  logic [1:0][1:0] rsp_din, rsp_dout;
  logic [1:0][OutW-1:0] outst_q, outst_d;
  logic [1:0] acc0_q, acc0_d;
  logic req_rr_q, req_rr_d, rsp_rr_q, rsp_rr_d;
  logic [1:0] req_v_q, rsp_v_q;
  logic [ReqW-1:0] req_data_q, req_data_d;
  logic [ErrBits-1:0] rsp_err_q, rsp_err_d;
  logic ovf_q, ovf_d, r_fire, drop;
  assign r_fire = r_valid_i & r_ready_i;
  assign req_push = {aw_valid_i & aw_ready_i, ar_valid_i & ar_ready_i};
  assign rsp_push = {b_valid_i & b_ready_i, r_fire & r_last_i};
  assign req_din[CH_RD] = {ar_addr_i, ar_meta_i};
  assign req_din[CH_WR] = {aw_addr_i, aw_meta_i};
  // the burst reports its first SLVERR/DECERR, otherwise the last beat's own code
  assign rsp_din[CH_RD] = acc0_q[1] ? acc0_q : r_resp_i;
  assign rsp_din[CH_WR] = b_resp_i;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    bus_err_tap_fifo #(.Width(ReqW), .Depth(QueueDepth)) u_req (
      .clk_i, .rst_i, .push_i(req_push[c]), .pop_i(req_pop[c]), .data_i(req_din[c]),
      .data_o(req_dout[c]), .full_o(req_full[c]), .empty_o(req_empty[c])
    );
    bus_err_tap_fifo #(.Width(2), .Depth(QueueDepth)) u_rsp (
      .clk_i, .rst_i, .push_i(rsp_push[c]), .pop_i(rsp_pop[c]), .data_i(rsp_din[c]),
      .data_o(rsp_dout[c]), .full_o(rsp_full[c]), .empty_o(rsp_empty[c])
    );
    assign req_elig[c] = (!req_empty[c] || req_push[c]) && outst_q[c] < MaxOut;
    assign rsp_elig[c] = (!rsp_empty[c] || rsp_push[c]) && outst_q[c] != '0;
    assign outst_d[c] = (req_pop[c] && !rsp_pop[c]) ? outst_q[c] + 1'b1 :
                        (rsp_pop[c] && !req_pop[c]) ? outst_q[c] - 1'b1 : outst_q[c];
  end
  always_comb begin
    acc0_d     = !r_fire ? acc0_q : r_last_i ? RESP_OKAY :
                 (!acc0_q[1] && r_resp_i[1]) ? r_resp_i : acc0_q;
    req_pop    = rr_pick(req_elig, req_rr_q);
    rsp_pop    = rr_pick(rsp_elig, rsp_rr_q);
    req_rr_d   = &req_elig ? ~req_rr_q : req_rr_q;
    rsp_rr_d   = &rsp_elig ? ~rsp_rr_q : rsp_rr_q;
    req_data_d = req_pop[CH_WR] ? req_dout[CH_WR] : req_pop[CH_RD] ? req_dout[CH_RD] : '0;
    rsp_err_d  = ErrBits'(rsp_pop[CH_WR] ? rsp_dout[CH_WR] : rsp_pop[CH_RD] ? rsp_dout[CH_RD] : RESP_OKAY);
    drop       = |((req_push & req_full & ~req_pop) | (rsp_push & rsp_full & ~rsp_pop));
    ovf_d      = drop | (ovf_q & ~clear_i);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc0_q     <= RESP_OKAY;
      outst_q    <= '0;
      req_rr_q   <= 1'b0;
      rsp_rr_q   <= 1'b0;
      req_v_q    <= '0;
      req_data_q <= '0;
      rsp_v_q    <= '0;
      rsp_err_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      acc0_q     <= acc0_d;
      outst_q    <= outst_d;
      req_rr_q   <= req_rr_d;
      rsp_rr_q   <= rsp_rr_d;
      req_v_q    <= req_pop;
      req_data_q <= req_data_d;
      rsp_v_q    <= rsp_pop;
      rsp_err_q  <= rsp_err_d;
      ovf_q      <= ovf_d;
    end
  end
  assign req_hs_valid_o   = req_v_q;
  assign req_addr_o       = req_data_q[ReqW-1 -: AddrWidth];
  assign req_meta_o       = req_data_q[MetaDataWidth-1:0];
  assign rsp_hs_valid_o   = rsp_v_q;
  assign rsp_burst_last_o = rsp_v_q;
  assign rsp_err_o        = rsp_err_q;
  assign overflow_o       = ovf_q;
endmodule

// File: tb/tb_bus_err_axi_tap.sv
// tb_bus_err_axi_tap: table-driven bursts plus hand-written corner sequences, scoreboarded per channel
module tb_bus_err_axi_tap;
  import bus_err_axi_tap_pkg::*;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic ar_valid_i = 0, ar_ready_i = 1, aw_valid_i = 0, aw_ready_i = 1;
  logic [47:0] ar_addr_i = '0, aw_addr_i = '0;
  logic ar_meta_i = 0, aw_meta_i = 0;
  logic r_valid_i = 0, r_ready_i = 1, r_last_i = 0, b_valid_i = 0, b_ready_i = 1, clear_i = 0;
  logic [1:0] r_resp_i = '0, b_resp_i = '0;
  logic [1:0] req_hs_valid_o, rsp_hs_valid_o, rsp_burst_last_o;
  logic [47:0] req_addr_o;
  logic req_meta_o, overflow_o;
  logic [2:0] rsp_err_o;
  int n_chk = 0, n_fail = 0;
  req_entry_t eq_req0[$], eq_req1[$];
  logic [2:0] eq_rsp0[$], eq_rsp1[$];
  typedef struct {logic wr; logic [47:0] addr; int beats; logic [7:0] resp; logic [2:0] err;} vec_t;
  vec_t tv[8];

  bus_err_axi_tap dut (
    .clk_i(clk), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_i(ar_ready_i), .ar_addr_i(ar_addr_i), .ar_meta_i(ar_meta_i),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_addr_i(aw_addr_i), .aw_meta_i(aw_meta_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_resp_i(r_resp_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_resp_i(b_resp_i), .clear_i(clear_i),
    .req_hs_valid_o(req_hs_valid_o), .req_addr_o(req_addr_o), .req_meta_o(req_meta_o),
    .rsp_hs_valid_o(rsp_hs_valid_o), .rsp_burst_last_o(rsp_burst_last_o), .rsp_err_o(rsp_err_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ar_valid_i = 0; aw_valid_i = 0; r_valid_i = 0; r_last_i = 0; b_valid_i = 0; clear_i = 0;
  endtask

  task automatic set_ar(input logic [47:0] a, input logic exp);
    ar_valid_i = 1; ar_addr_i = a; ar_meta_i = a[4];
    if (exp) eq_req0.push_back('{addr: a, meta: a[4]});
  endtask

  task automatic set_aw(input logic [47:0] a, input logic exp);
    aw_valid_i = 1; aw_addr_i = a; aw_meta_i = a[4];
    if (exp) eq_req1.push_back('{addr: a, meta: a[4]});
  endtask

  task automatic set_r(input logic [1:0] resp, input logic last, input logic [2:0] exp);
    r_valid_i = 1; r_resp_i = resp; r_last_i = last;
    if (last) eq_rsp0.push_back(exp);
  endtask

  task automatic set_b(input logic [1:0] resp, input logic [2:0] exp);
    b_valid_i = 1; b_resp_i = resp;
    eq_rsp1.push_back(exp);
  endtask

  task automatic ev_req(input string n, input logic [1:0] v, input logic [47:0] a);
    chk({n, "_valid"}, 64'(req_hs_valid_o), 64'(v));
    if (v != 2'b00) chk({n, "_addr"}, 64'(req_addr_o), 64'(a));
  endtask

  task automatic ev_rsp(input string n, input logic [1:0] v, input logic [2:0] e);
    chk({n, "_valid"}, 64'(rsp_hs_valid_o), 64'(v));
    chk({n, "_last"}, 64'(rsp_burst_last_o), 64'(v));
    if (v != 2'b00) chk({n, "_err"}, 64'(rsp_err_o), 64'(e));
  endtask

  // scoreboard: every emitted event must match the head of its channel's expectation queue
  always @(negedge clk) if (!rst_i) begin
    req_entry_t e;
    logic [2:0] x;
    if (req_hs_valid_o == 2'b01 || req_hs_valid_o == 2'b10) begin
      if (req_hs_valid_o[0] ? eq_req0.size() == 0 : eq_req1.size() == 0)
        chk("sb_req_unexpected", 64'(req_hs_valid_o), 64'(0));
      else begin
        if (req_hs_valid_o[0]) e = eq_req0.pop_front(); else e = eq_req1.pop_front();
        chk("sb_req_entry", 64'({req_addr_o, req_meta_o}), 64'(e));
      end
    end else if (req_hs_valid_o != 2'b00) chk("sb_req_onehot", 64'(req_hs_valid_o), 64'(1));
    if (rsp_hs_valid_o == 2'b01 || rsp_hs_valid_o == 2'b10) begin
      if (rsp_hs_valid_o[0] ? eq_rsp0.size() == 0 : eq_rsp1.size() == 0)
        chk("sb_rsp_unexpected", 64'(rsp_hs_valid_o), 64'(0));
      else begin
        if (rsp_hs_valid_o[0]) x = eq_rsp0.pop_front(); else x = eq_rsp1.pop_front();
        chk("sb_rsp_err", 64'(rsp_err_o), 64'(x));
        chk("sb_rsp_last", 64'(rsp_burst_last_o), rsp_hs_valid_o[0] ? 64'(1) : 64'(2));
      end
    end else if (rsp_hs_valid_o != 2'b00) chk("sb_rsp_onehot", 64'(rsp_hs_valid_o), 64'(1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b0, 48'h2000, 1, 8'h01, 3'd1};
    tv[1] = '{1'b0, 48'h2110, 2, 8'h0C, 3'd3};
    tv[2] = '{1'b0, 48'h2200, 3, 8'h0E, 3'd2};
    tv[3] = '{1'b0, 48'h2310, 4, 8'h45, 3'd1};
    tv[4] = '{1'b0, 48'h2400, 2, 8'h07, 3'd3};
    tv[5] = '{1'b1, 48'h3000, 1, 8'h00, 3'd0};
    tv[6] = '{1'b1, 48'h3110, 1, 8'h02, 3'd2};
    tv[7] = '{1'b1, 48'hFFFF_FFFF_FFF0, 1, 8'h01, 3'd1};
    repeat (3) @(posedge clk);
    #1;
    ev_req("rst", 2'b00, '0);
    ev_rsp("rst", 2'b00, '0);
    chk("rst_addr", 64'(req_addr_o), 64'(0));
    chk("rst_ovf", 64'(overflow_o), 64'(0));
    rst_i = 0;
    cyc();
    ar_ready_i = 0; set_ar(48'h9990, 1'b0); cyc(); ar_ready_i = 1;
    ev_req("no_ready", 2'b00, '0);
    cyc();
    ev_req("no_ready_late", 2'b00, '0);
    // single 4-beat read, first error SLVERR wins over later DECERR
    set_ar(48'h1000, 1'b1); cyc();
    ev_req("rd1_req", 2'b01, 48'h1000);
    set_r(RESP_OKAY, 0, 0); cyc(); ev_rsp("rd1_b0", 2'b00, 0);
    set_r(RESP_SLVERR, 0, 0); cyc(); ev_rsp("rd1_b1", 2'b00, 0);
    set_r(RESP_DECERR, 0, 0); cyc(); ev_rsp("rd1_b2", 2'b00, 0);
    set_r(RESP_OKAY, 1, 3'd2); cyc(); ev_rsp("rd1_last", 2'b01, 3'd2);
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (tv[i].wr) set_aw(tv[i].addr, 1'b1); else set_ar(tv[i].addr, 1'b1);
      cyc();
      ev_req("tv_req", tv[i].wr ? 2'b10 : 2'b01, tv[i].addr);
      for (int b = 0; b < tv[i].beats; b++) begin
        if (tv[i].wr) set_b(tv[i].resp[1:0], tv[i].err);
        else set_r(tv[i].resp[2*b +: 2], b == tv[i].beats - 1, tv[i].err);
        cyc();
      end
      ev_rsp("tv_rsp", tv[i].wr ? 2'b10 : 2'b01, tv[i].err);
      cyc();
    end
    // collisions alternate starting from the read channel
    set_ar(48'hA0, 1'b1); set_aw(48'hB0, 1'b1); cyc(); ev_req("col1_a", 2'b01, 48'hA0);
    cyc(); ev_req("col1_b", 2'b10, 48'hB0);
    set_ar(48'hA4, 1'b1); set_aw(48'hB4, 1'b1); cyc(); ev_req("col2_a", 2'b10, 48'hB4);
    cyc(); ev_req("col2_b", 2'b01, 48'hA4);
    repeat (2) begin set_r(RESP_OKAY, 1, 0); set_b(RESP_OKAY, 0); cyc(); end
    repeat (4) cyc();
    // B arrives before its AW has been emitted: response waits for the request
    set_ar(48'hC0, 1'b1); set_aw(48'hD0, 1'b1); cyc(); ev_req("bfirst_rd", 2'b01, 48'hC0);
    set_b(RESP_DECERR, 3'd3); cyc();
    ev_req("bfirst_wr", 2'b10, 48'hD0); ev_rsp("bfirst_held", 2'b00, 0);
    cyc(); ev_rsp("bfirst_rsp", 2'b10, 3'd3);
    set_r(RESP_OKAY, 1, 0); cyc();
    repeat (3) cyc();
    // outstanding limit
    for (int i = 0; i < 5; i++) begin
      set_ar(48'h100 + 48'(i * 16), 1'b1); cyc();
      ev_req("mo_req", i < 4 ? 2'b01 : 2'b00, 48'h100 + 48'(i * 16));
    end
    cyc(); ev_req("mo_idle", 2'b00, '0);
    set_r(RESP_OKAY, 1, 0); cyc(); ev_rsp("mo_rsp", 2'b01, 0); ev_req("mo_still", 2'b00, '0);
    cyc(); ev_req("mo_5th", 2'b01, 48'h140);
    repeat (4) begin set_r(RESP_OKAY, 1, 0); cyc(); end
    repeat (3) cyc();
    // overflow, clear, and drop-vs-clear priority
    for (int i = 0; i < 4; i++) begin set_ar(48'h7000 + 48'(i * 16), 1'b1); cyc(); end
    set_ar(48'h7040, 1'b1); cyc(); chk("ovf_q1", 64'(overflow_o), 64'(0));
    set_ar(48'h7050, 1'b1); cyc(); chk("ovf_q2", 64'(overflow_o), 64'(0));
    set_ar(48'h7060, 1'b0); cyc(); chk("ovf_drop", 64'(overflow_o), 64'(1));
    clear_i = 1; cyc(); chk("ovf_clear", 64'(overflow_o), 64'(0));
    set_ar(48'h7070, 1'b0); clear_i = 1; cyc(); chk("ovf_drop_clear", 64'(overflow_o), 64'(1));
    clear_i = 1; cyc(); chk("ovf_clear2", 64'(overflow_o), 64'(0));
    set_r(RESP_OKAY, 1, 0); cyc(); ev_rsp("ovf_rsp", 2'b01, 0);
    set_ar(48'h7080, 1'b1); cyc();
    chk("ovf_pushpop_full", 64'(overflow_o), 64'(0)); ev_req("ovf_pop", 2'b01, 48'h7040);
    repeat (6) begin set_r(RESP_OKAY, 1, 0); cyc(); end
    repeat (4) cyc();
    // reset in the middle of an erroring burst
    set_ar(48'h5000, 1'b1); cyc();
    set_r(RESP_DECERR, 0, 0); cyc();
    set_aw(48'h5100, 1'b1); set_r(RESP_SLVERR, 0, 0); cyc(); ev_req("mid_pre", 2'b10, 48'h5100);
    rst_i = 1; #1;
    ev_req("mid_rst", 2'b00, '0); ev_rsp("mid_rst", 2'b00, 0);
    chk("mid_rst_ovf", 64'(overflow_o), 64'(0));
    eq_req0.delete(); eq_req1.delete(); eq_rsp0.delete(); eq_rsp1.delete();
    @(posedge clk); #1; rst_i = 0;
    set_ar(48'h6000, 1'b1); cyc(); ev_req("post_rst_req", 2'b01, 48'h6000);
    set_r(RESP_OKAY, 1, 0); cyc(); ev_rsp("post_rst_rsp", 2'b01, 0);
    repeat (4) cyc();
    chk("sb_req0_drained", 64'(eq_req0.size()), 64'(0));
    chk("sb_req1_drained", 64'(eq_req1.size()), 64'(0));
    chk("sb_rsp0_drained", 64'(eq_rsp0.size()), 64'(0));
    chk("sb_rsp1_drained", 64'(eq_rsp1.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_err_axi_tap.md
Name: bus_err_axi_tap

Overview:
- Passive AXI4 monitor that sits directly upstream of the bus error unit.
- Observes AR/R (channel 0, read) and AW/B (channel 1, write) handshakes on one port.
- Converts them into the error unit's one-hot request/response event interface: at most one request event and one response event per cycle, in per-channel order, with per-burst read error accumulation.
- Never drives or stalls the bus.

Parameters:
AddrWidth, 48, AXI address width
MetaDataWidth, 1, sideband captured with each request (e.g. ID/user)
ErrBits, 3, width of rsp_err_o; must be >= 2
QueueDepth, 2, entries per channel in each request and response queue
MaxOutstanding, 4, per-channel limit on emitted-but-unanswered requests

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ar_valid_i / ar_ready_i  in  1/1  AR handshake
ar_addr_i  in  AddrWidth  read address
ar_meta_i  in  MetaDataWidth  read sideband
aw_valid_i / aw_ready_i  in  1/1  AW handshake
aw_addr_i  in  AddrWidth  write address
aw_meta_i  in  MetaDataWidth  write sideband
r_valid_i / r_ready_i / r_last_i  in  1/1/1  R beat handshake and last flag
r_resp_i  in  2  R response code
b_valid_i / b_ready_i  in  1/1  B handshake
b_resp_i  in  2  B response code
clear_i  in  1  clears overflow_o
req_hs_valid_o  out  2  one-hot request event; bit0 = read, bit1 = write
req_addr_o  out  AddrWidth  address of request event
req_meta_o  out  MetaDataWidth  sideband of request event
rsp_hs_valid_o  out  2  one-hot response event
rsp_burst_last_o  out  2  set with every response event
rsp_err_o  out  ErrBits  error code, zero-extended from 2 bits
overflow_o  out  1  sticky: an event was dropped

Behaviour:
- All outputs are registered. Reset (async, rst_i=1): all outputs are 0, queues empty, counters 0, accumulators OKAY, arbiters point to channel 0.
- Capture:
  - AR fire (valid & ready) pushes {addr, meta} into reqQ[0]; AW fire pushes into reqQ[1].
  - B fire pushes b_resp into rspQ[1].
  - Each R fire updates acc0: if acc0 is 2'b0x and r_resp[1]=1, acc0 <= r_resp (the first SLVERR/DECERR wins).
  - When the fire carries r_last, push (updated acc0, or r_resp when acc0 is still OKAY/EXOKAY) into rspQ[0], then reset acc0 to OKAY.
  - Single-beat bursts behave the same way.
- Request output:
  - Each cycle, pick at most one channel with a non-empty reqQ and outst[c] < MaxOutstanding.
  - Round-robin: when both are eligible, alternate, starting from channel 0 after reset.
  - The next cycle drives req_hs_valid_o one-hot with that entry. The entry pops and outst[c] increments.
- Response output:
  - A channel is eligible when rspQ[c] is non-empty and outst[c] > 0. This guarantees a request event always precedes its response event.
  - At most one channel per cycle, with an independent round-robin.
  - The next cycle drives rsp_hs_valid_o[c]=1, rsp_burst_last_o[c]=1, rsp_err_o=zero-extended code. The entry pops and outst[c] decrements.
- A request emit and a response emit on the same channel in the same cycle leave outst unchanged.
- Latency: an isolated event captured in cycle t appears on the outputs in cycle t+1.
- A push and a pop on the same queue in the same cycle are allowed when the queue is full; no drop occurs.
- A push to a full queue with no pop in that cycle drops the new event and sets overflow_o.
- overflow_o clears on clear_i. If a drop and clear_i happen in the same cycle, overflow_o stays set.
- Reset asserted mid-burst discards acc0 and all queued events.

Decomposition:
- Shared package bus_err_axi_tap_pkg: AXI resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), channel index constants, and a req_entry_t typedef {addr, meta}.
- One natural sub-module, bus_err_tap_fifo: a parameterised fall-through queue with push/pop/full/empty, instantiated 4 times.

Test Plan:
- Single read: AR addr 0x1000 at t0, 4-beat R with resp 0,2,3,0 -> req_hs_valid_o=01 with addr 0x1000 at t0+1; after the last beat, rsp_hs_valid_o=01, rsp_burst_last_o=01, rsp_err_o=3'b010.
- AR and AW fire in the same cycle (addr 0xA0 / 0xB0) -> req event ch0 0xA0 in cycle t+1, ch1 0xB0 in t+2; next collision serves ch1 first.
- Write B (resp DECERR) fires before its AW is emitted because the request queue is busy -> rsp event ch1 appears only after the AW req event, with rsp_err_o=3.
- MaxOutstanding=4 and 5 ARs with no R -> 4 req events, the 5th is held; after one R last, the 5th is emitted the cycle after that response event.
- QueueDepth=2 with 3 collision-induced backlogged ARs beyond capacity -> overflow_o=1 and the dropped address is never emitted; clear_i -> overflow_o=0 next cycle.
- rst_i asserted mid-burst -> all outputs 0 immediately; a subsequent single-beat R OKAY after a new AR yields rsp_err_o=0.
